// File: rtl/btn_db_pkg.sv
// ============================================================================
// Module  : btn_db_pkg
// Purpose : Shared types and register indices for the button debounce core.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package btn_db_pkg;

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_t;

   localparam int unsigned ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_DB    = 5'd0;
   localparam logic [ADDR_W-1:0] REG_RAW   = 5'd1;
   localparam logic [ADDR_W-1:0] REG_PRESS = 5'd2;
   localparam logic [ADDR_W-1:0] REG_REL   = 5'd3;

endpackage

`default_nettype wire

// File: rtl/debounce_fsm.sv
// ============================================================================
// Module  : debounce_fsm
// Purpose : Single-bit debounce filter; db changes after 2^N stable samples.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module debounce_fsm
   import btn_db_pkg::*;
#(
   parameter int N = 20
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sync_i,
   output logic db_out_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   // The sample that moves the FSM into a WAIT state is the first of the 2^N
   // stable samples, so the counter only has to reach 2^N-2 before the switch.
   localparam int unsigned      c_term_int = (2 ** N) - 2;
   localparam logic [N-1:0]     c_cnt_term = c_term_int[N-1:0];

   db_state_t    state_q;
   logic [N-1:0] cnt_q;
   logic         db_q;
   logic         w_at_term;

   assign w_at_term = (cnt_q == c_cnt_term);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ZERO;
         cnt_q   <= '0;
         db_q    <= 1'b0;
      end else begin
         case (state_q)
            ZERO: begin
               if (sync_i) begin
                  state_q <= WAIT1;
                  cnt_q   <= '0;
               end
            end
            WAIT1: begin
               if (!sync_i) begin
                  state_q <= ZERO;
               end else if (w_at_term) begin
                  state_q <= ONE;
                  db_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ONE: begin
               if (!sync_i) begin
                  state_q <= WAIT0;
                  cnt_q   <= '0;
               end
            end
            WAIT0: begin
               if (sync_i) begin
                  state_q <= ONE;
               end else if (w_at_term) begin
                  state_q <= ZERO;
                  db_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ZERO;
               cnt_q   <= '0;
               db_q    <= 1'b0;
            end
         endcase
      end
   end

   // Ticks are decoded from current state so the core's flags load on the
   // same edge that db changes.
   assign rise_tick_o = (state_q == WAIT1) &  sync_i & w_at_term;
   assign fall_tick_o = (state_q == WAIT0) & ~sync_i & w_at_term;
   assign db_out_o    = db_q;

endmodule

`default_nettype wire

// File: rtl/btn_debounce_core.sv
// ============================================================================
// Module  : btn_debounce_core
// Purpose : MMIO slot core debouncing W buttons with sticky press/release flags.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module btn_debounce_core
   import btn_db_pkg::*;
#(
   parameter int W = 5,
   parameter int N = 20
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cs_i,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [31:0]       rd_data_o,
   input  logic [31:0]       wr_data_i,
   input  logic [W-1:0]      din_i
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic [W-1:0] w_db;
   logic [W-1:0] w_rise;
   logic [W-1:0] w_fall;
   logic [W-1:0] press_q, press_d;
   logic [W-1:0] rel_q,   rel_d;
   logic [W-1:0] w_press_clr;
   logic [W-1:0] w_rel_clr;
   logic         w_wr_en;
   logic         w_unused;

   // Reads have no side effects and upper write-data bits are not stored.
   assign w_unused = ^{read_i, wr_data_i};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= din_i;
         sync_q <= meta_q;
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_bit
      debounce_fsm #(
         .N (N)
      ) u_fsm (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .sync_i      (sync_q[i]),
         .db_out_o    (w_db[i]),
         .rise_tick_o (w_rise[i]),
         .fall_tick_o (w_fall[i])
      );
   end

   assign w_wr_en     = cs_i & write_i;
   assign w_press_clr = (w_wr_en && addr_i == REG_PRESS) ? wr_data_i[W-1:0] : '0;
   assign w_rel_clr   = (w_wr_en && addr_i == REG_REL)   ? wr_data_i[W-1:0] : '0;

   // A new event on the same edge as its clear keeps the flag set.
   assign press_d = (press_q & ~w_press_clr) | w_rise;
   assign rel_d   = (rel_q   & ~w_rel_clr)   | w_fall;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         press_q <= '0;
         rel_q   <= '0;
      end else begin
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      case (addr_i)
         REG_DB:    rd_data_o[W-1:0] = w_db;
         REG_RAW:   rd_data_o[W-1:0] = sync_q;
         REG_PRESS: rd_data_o[W-1:0] = press_q;
         REG_REL:   rd_data_o[W-1:0] = rel_q;
         default:   rd_data_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_core.sv
// ============================================================================
// Module  : tb_btn_debounce_core
// Purpose : Directed self-checking bench for btn_debounce_core (W=5, N=4).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_btn_debounce_core;

   localparam int W = 5;
   localparam int N = 4;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        cs_i;
   logic        read_i;
   logic        write_i;
   logic [4:0]  addr_i;
   logic [31:0] rd_data_o;
   logic [31:0] wr_data_i;
   logic [W-1:0] din_i;

   int n_checks = 0;
   int n_errors = 0;

   btn_debounce_core #(
      .W (W),
      .N (N)
   ) u_dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .cs_i      (cs_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .addr_i    (addr_i),
      .rd_data_o (rd_data_o),
      .wr_data_i (wr_data_i),
      .din_i     (din_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      addr_i = a;
      read_i = 1'b1;
      #1;
      chk(tag, rd_data_o, exp);
      read_i = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic sel);
      cs_i      = sel;
      write_i   = 1'b1;
      addr_i    = a;
      wr_data_i = d;
      @(posedge clk_i);
      #1;
      cs_i      = 1'b0;
      write_i   = 1'b0;
      wr_data_i = '0;
   endtask

   initial begin
      reset_i   = 1'b1;
      cs_i      = 1'b0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      addr_i    = '0;
      wr_data_i = '0;
      din_i     = '0;

      // 1: reset state
      tick(3);
      reset_i = 1'b0;
      tick(1);
      rd("rst_db",    5'd0, 32'h0);
      rd("rst_raw",   5'd1, 32'h0);
      rd("rst_press", 5'd2, 32'h0);
      rd("rst_rel",   5'd3, 32'h0);
      rd("rst_addr9", 5'd9, 32'h0);

      // 2: clean press of bit 0, latency 18 edges
      din_i = 5'b00001;
      tick(1);
      rd("raw_1edge", 5'd1, 32'h0);
      tick(1);
      rd("raw_2edge", 5'd1, 32'h1);
      tick(15);
      rd("db_17edge",    5'd0, 32'h0);
      rd("press_17edge", 5'd2, 32'h0);
      tick(1);
      rd("db_18edge",    5'd0, 32'h1);
      rd("press_18edge", 5'd2, 32'h1);
      wr(5'd2, 32'h1, 1'b1);
      rd("press_w1c", 5'd2, 32'h0);

      // 3: 10-cycle glitch on bit 1
      din_i = 5'b00011;
      tick(2);
      rd("glitch_raw", 5'd1, 32'h3);
      tick(8);
      din_i = 5'b00001;
      tick(25);
      rd("glitch_db",    5'd0, 32'h1);
      rd("glitch_press", 5'd2, 32'h0);
      rd("glitch_rel",   5'd3, 32'h0);

      // 4: bounce on bit 2, then hold and release
      for (int i = 0; i < 6; i++) begin
         din_i[2] = (i % 2 == 0);
         tick(3);
      end
      din_i[2] = 1'b1;
      tick(17);
      rd("bounce_db17",    5'd0, 32'h1);
      rd("bounce_press17", 5'd2, 32'h0);
      tick(1);
      rd("bounce_db18",    5'd0, 32'h5);
      rd("bounce_press18", 5'd2, 32'h4);
      din_i[2] = 1'b0;
      tick(17);
      rd("rel_17", 5'd3, 32'h0);
      tick(1);
      rd("rel_18",    5'd3, 32'h4);
      rd("rel_db18",  5'd0, 32'h1);
      wr(5'd3, 32'h4, 1'b1);
      rd("rel_w1c", 5'd3, 32'h0);

      // 5: press set coincides with W1C of the same bit
      din_i = 5'b00000;
      tick(18);
      rd("rel0_db",  5'd0, 32'h0);
      rd("rel0_rel", 5'd3, 32'h1);
      wr(5'd3, 32'hFFFF_FFFF, 1'b1);
      rd("rel_clr_all", 5'd3, 32'h0);
      wr(5'd2, 32'h1F, 1'b1);
      rd("press_clr_all", 5'd2, 32'h0);
      din_i = 5'b00001;
      tick(17);
      wr(5'd2, 32'h1, 1'b1);
      rd("set_wins", 5'd2, 32'h1);
      wr(5'd2, 32'h1, 1'b0);
      rd("nocs_ignored", 5'd2, 32'h1);
      wr(5'd9, 32'h1, 1'b1);
      rd("addr9_wr_ignored", 5'd2, 32'h1);
      wr(5'd2, 32'h1, 1'b1);
      rd("press_clear", 5'd2, 32'h0);

      // 6: reset in the middle of bit 3 filtering
      din_i = 5'b01001;
      tick(8);
      rd("pre_rst_db", 5'd0, 32'h1);
      reset_i = 1'b1;
      tick(1);
      reset_i = 1'b0;
      rd("mid_rst_db",    5'd0, 32'h0);
      rd("mid_rst_raw",   5'd1, 32'h0);
      rd("mid_rst_press", 5'd2, 32'h0);
      tick(17);
      rd("requal_db17", 5'd0, 32'h0);
      tick(1);
      rd("requal_db18",    5'd0, 32'h9);
      rd("requal_press18", 5'd2, 32'h9);
      rd("requal_rel18",   5'd3, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
